// File: rtl/uart_pkg.sv
// Types and helpers shared by the host-link UART receiver and transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_t;

  function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Received-byte stream plus error pulses; master is the receiver, slave the consumer.
interface uart_rx_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  overrun,
    output rx_ready
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, with a selectable reset value.
module sync_2ff #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, false-start rejection, framing-error and overrun
// reporting, delivering bytes through a one-entry holding register on a valid/ready stream.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST    = 16'(HALF_BIT - 1);

  uart_state_t r_state;
  uart_state_t w_state_next;
  logic [15:0] r_clk_count;
  logic [2:0]  r_bit_index;
  logic [7:0]  r_shift;
  logic [7:0]  r_data;
  logic        r_valid;
  logic        r_frame_err;
  logic        r_overrun;
  logic        w_rx_s;
  logic        w_shift;
  logic        w_deliver;
  logic        w_frame_err;
  logic        w_accept;
  logic        w_counting;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift      = 1'b0;
    w_deliver    = 1'b0;
    w_frame_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) w_state_next = START;
      end
      START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (r_clk_count == HALF_LAST) w_state_next = w_rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (r_clk_count == BIT_LAST) begin
          w_shift = 1'b1;
          if (r_bit_index == 3'd7) w_state_next = STOP;
        end
      end
      STOP: begin
        if (r_clk_count == BIT_LAST) begin
          if (w_rx_s) begin
            w_deliver    = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_frame_err  = 1'b1;
            w_state_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        if (w_rx_s) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_counting = (r_state == START) || (r_state == DATA) || (r_state == STOP);

  // The bit timer restarts on every state change and after each data sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_count <= '0;
      r_bit_index <= '0;
      r_shift     <= '0;
    end else begin
      if (w_shift) r_shift <= {w_rx_s, r_shift[7:1]};
      if (w_state_next != r_state) begin
        r_clk_count <= '0;
        r_bit_index <= '0;
      end else if (w_shift) begin
        r_clk_count <= '0;
        r_bit_index <= r_bit_index + 3'd1;
      end else if (w_counting) begin
        r_clk_count <= r_clk_count + 16'd1;
      end
    end
  end

  assign w_accept = r_valid && bus.rx_ready;

  // A new byte may replace the held one only if the consumer takes it in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_err;
      r_overrun   <= 1'b0;
      if (w_deliver) begin
        if (!r_valid || w_accept) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.rx_data   = r_data;
  assign bus.rx_valid  = r_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx at 16 clocks per bit, with directed boundary scenarios.
module tb_uart_rx;

  logic clk;
  logic rst;
  logic rx;
  logic rx_ready;
  logic rand_rdy;

  uart_rx_if bus();
  assign bus.rx_ready = rx_ready;

  uart_rx #(
    .CLOCK_FREQ (16),
    .BAUD_RATE  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int          cyc      = 0;
  int          t_start  = 0;
  int          req_cnt  = 0;
  int          done_cnt = 0;
  logic [7:0]  req_byte = 8'h00;
  logic        req_stop = 1'b1;
  logic        m_full   = 1'b0;
  int          ferr_exp = 0;
  int          ovr_exp  = 0;
  logic [7:0]  exp_q[$];

  int          ferr_seen = 0;
  int          ovr_seen  = 0;
  int          acc_cnt   = 0;
  int          rise_cyc  = 0;
  int          run_len   = 0;
  int          last_len  = 0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic        prev_ferr  = 1'b0;
  logic [7:0]  prev_data  = 8'h00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
  endtask

  // Reference model: one-entry holding buffer driven by the bench's own frame requests.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_full = 1'b0;
        exp_q.delete();
        done_cnt = req_cnt;
      end else if (req_cnt != done_cnt) begin
        done_cnt = req_cnt;
        if (!req_stop) begin
          ferr_exp++;
        end else if (!m_full || rx_ready) begin
          exp_q.push_back(req_byte);
          m_full = 1'b1;
        end else begin
          ovr_exp++;
        end
      end else if (m_full && rx_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted byte and tallies error pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        prev_ferr  = 1'b0;
        run_len    = 0;
      end else begin
        if (bus.rx_valid && prev_valid && !prev_ready)
          chk("data_stable", 32'(bus.rx_data), 32'(prev_data));
        if (bus.rx_valid && !prev_valid) rise_cyc = cyc;
        if (bus.rx_valid) begin
          run_len++;
        end else if (run_len > 0) begin
          last_len = run_len;
          run_len  = 0;
        end
        if (bus.rx_valid && rx_ready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no byte", bus.rx_data);
          end else begin
            chk("accept_data", 32'(bus.rx_data), 32'(exp_q.pop_front()));
          end
        end
        if (bus.frame_err) begin
          ferr_seen++;
          chk("ferr_width", 32'(prev_ferr), 0);
          chk("ferr_ovr_exclusive", 32'(bus.overrun), 0);
        end
        if (bus.overrun) ovr_seen++;
        prev_valid = bus.rx_valid;
        prev_ready = rx_ready;
        prev_data  = bus.rx_data;
        prev_ferr  = bus.frame_err;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] data, input logic stop, input logic ready_on_stop);
    logic [8:0] bits;
    bits    = {data, 1'b0};
    t_start = cyc + 1;
    for (int i = 0; i < 9; i++) begin
      rx = bits[i];
      repeat (16) tick();
    end
    rx = stop;
    repeat (10) tick();
    req_byte = data;
    req_stop = stop;
    req_cnt++;
    if (ready_on_stop) rx_ready = 1'b1;
    tick();
    if (ready_on_stop) rx_ready = 1'b0;
    repeat (5) tick();
  endtask

  task automatic sendPartialWithReset(input logic [7:0] data);
    rx = 1'b0;
    repeat (16) tick();
    for (int i = 0; i < 4; i++) begin
      rx = data[i];
      repeat (16) tick();
    end
    rx = data[4];
    repeat (5) tick();
    rx  = 1'b1;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic valid, input logic [7:0] data);
    chk({name, "_valid"}, 32'(bus.rx_valid), 32'(valid));
    if (valid) chk({name, "_data"}, 32'(bus.rx_data), 32'(data));
  endtask

  initial begin
    int acc0;
    logic [7:0] b;
    logic       s;
    int         gap;

    rand_rdy = 1'b0;
    rst      = 1'b1;
    rx       = 1'b0;
    rx_ready = 1'b0;
    repeat (3) tick();
    chk("reset_data", 32'(bus.rx_data), 0);
    chk("reset_valid", 32'(bus.rx_valid), 0);
    chk("reset_ferr", 32'(bus.frame_err), 0);
    chk("reset_ovr", 32'(bus.overrun), 0);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (40) tick();
    chk("idle_no_byte", acc_cnt, 0);
    chk("idle_valid", 32'(bus.rx_valid), 0);

    $display("[TB] single byte");
    rx_ready = 1'b1;
    applyStimulus(8'hA5, 1'b1, 1'b0);
    repeat (4) tick();
    chk("latency", rise_cyc - t_start, 154);
    chk("valid_width", last_len, 1);
    chk("single_count", acc_cnt, 1);

    $display("[TB] glitch");
    rx = 1'b0;
    repeat (4) tick();
    rx = 1'b1;
    repeat (30) tick();
    chk("glitch_no_byte", acc_cnt, 1);
    chk("glitch_no_ferr", ferr_seen, 0);
    applyStimulus(8'h3C, 1'b1, 1'b0);
    repeat (4) tick();
    chk("after_glitch_count", acc_cnt, 2);

    $display("[TB] framing error");
    applyStimulus(8'h3C, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (40) tick();
    rx = 1'b1;
    repeat (4) tick();
    chk("ferr_count", ferr_seen, 1);
    chk("ferr_no_byte", acc_cnt, 2);
    applyStimulus(8'h7E, 1'b1, 1'b0);
    repeat (4) tick();
    chk("after_ferr_count", acc_cnt, 3);

    $display("[TB] backpressure and overrun");
    rx_ready = 1'b0;
    applyStimulus(8'h11, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0);
    repeat (4) tick();
    checkOutput("held", 1'b1, 8'h11);
    chk("ovr_count", ovr_seen, 1);
    rx_ready = 1'b1;
    repeat (2) tick();
    chk("drained_valid", 32'(bus.rx_valid), 0);
    chk("drained_count", acc_cnt, 4);

    $display("[TB] simultaneous accept");
    rx_ready = 1'b0;
    applyStimulus(8'h11, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b1);
    repeat (2) tick();
    checkOutput("simul", 1'b1, 8'h22);
    chk("simul_no_ovr", ovr_seen, 1);
    rx_ready = 1'b1;
    repeat (4) tick();
    chk("simul_count", acc_cnt, 6);

    $display("[TB] reset mid-frame");
    rx_ready = 1'b0;
    applyStimulus(8'h5A, 1'b1, 1'b0);
    sendPartialWithReset(8'hF0);
    chk("midreset_valid", 32'(bus.rx_valid), 0);
    rx_ready = 1'b1;
    repeat (200) tick();
    chk("midreset_no_byte", acc_cnt, 6);
    applyStimulus(8'h96, 1'b1, 1'b0);
    repeat (4) tick();
    chk("after_reset_count", acc_cnt, 7);

    $display("[TB] random traffic");
    acc0     = acc_cnt;
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      b   = 8'($urandom_range(0, 255));
      s   = ($urandom_range(0, 5) != 0);
      gap = $urandom_range(0, 12);
      if (!s && gap < 3) gap = 3;
      applyStimulus(b, s, 1'b0);
      rx = 1'b1;
      repeat (gap) tick();
    end
    rand_rdy = 1'b0;
    rx_ready = 1'b1;
    repeat (50) tick();
    if (acc_cnt == acc0) $display("[TB] note: random phase delivered no bytes");

    chk("final_ferr", ferr_seen, ferr_exp);
    chk("final_ovr", ovr_seen, ovr_exp);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_valid", 32'(bus.rx_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: deserialises 8N1 frames from the asynchronous `rx` pin into bytes on a valid/ready stream, for host-to-TPU command and data input. It is the receive-side peer of the host-link transmitter and uses the same `CLOCK_FREQ`/`BAUD_RATE` parameterisation. It includes an input synchroniser, mid-bit sampling, false-start rejection, framing-error detection and overrun reporting.

## Interface
- `CLOCK_FREQ`, 100_000_000, system clock frequency in Hz
- `BAUD_RATE`, 115200, line rate in bits/s
- Derived values:
  - `CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE`, integer division. Legal range is 2..65535.
  - `HALF_BIT = CLKS_PER_BIT / 2`.
- `clk`  in  1  system clock, the only clock
- `rst`  in  1  synchronous, active-high reset
- `rx`  in  1  serial line, asynchronous to `clk`, idles high
- `rx_data`  out  8  received byte, stable while `rx_valid`=1
- `rx_valid`  out  1  byte available
- `rx_ready`  in  1  consumer accepts the byte when `rx_valid && rx_ready`
- `frame_err`  out  1  one-cycle pulse: the stop bit was sampled low
- `overrun`  out  1  one-cycle pulse: a completed byte was dropped because the holding register was full

## Operation
- **Synchroniser.** `rx` passes through two flops to produce `rx_s`. Both flops reset to 1. All FSM logic uses `rx_s` only.
- **Counters.** `clk_count` is 16 bits and `bit_index` is 3 bits. Both are cleared on every state change.
- **Bit order.** Data bits are sampled LSB first into `shift_reg[7:0]`, shifting right: the sampled bit enters bit 7, so after 8 samples bit 0 holds the first bit received.
- **FSM states:**
  - IDLE: if `rx_s`=0, go to START.
  - START: at `clk_count`==`HALF_BIT`-1, sample `rx_s`.
    - 0: go to DATA.
    - 1: glitch; return to IDLE and produce no output.
  - DATA: at `clk_count`==`CLKS_PER_BIT`-1, shift in `rx_s` and increment `bit_index`. After the sample with `bit_index`==7, go to STOP.
  - STOP: at `clk_count`==`CLKS_PER_BIT`-1, sample `rx_s`.
    - 1: deliver the byte (see Holding register), then go to IDLE.
    - 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`=1, then go to IDLE. This prevents a break condition from being decoded as repeated frames.
- **Holding register.** On delivery:
  - If `rx_valid`=0, or `rx_valid && rx_ready` in the same cycle: load `rx_data`, set `rx_valid`=1.
  - Otherwise: keep the old byte, pulse `overrun`, drop the new byte.
- **Clearing `rx_valid`.** It clears on `rx_valid && rx_ready` when no delivery occurs in that cycle.
- **Reset values:**
  - `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0.
  - FSM in IDLE, synchroniser flops = 1.
- **Reset mid-frame.** The partial byte is discarded. A pending unaccepted byte is also lost.

## Timing
- **Reference edge.** Let P be the first `clk` edge at which `rx`=0 is captured. IDLE registers `rx_s`=0 at edge E = P+2.
- **Sample edges.**
  - Start-bit check: E+`HALF_BIT`.
  - Data bit k: E+`HALF_BIT`+(k+1)·`CLKS_PER_BIT`.
  - Stop bit: E+`HALF_BIT`+9·`CLKS_PER_BIT`.
- **Output timing.** `rx_valid`, `frame_err` and `overrun` are registered and become visible immediately after the stop-sample edge. With the defaults (`CLKS_PER_BIT`=868, `HALF_BIT`=434) this is P+8248.
- **Back-to-back frames.** A new start bit is accepted from the first cycle in IDLE after the stop sample. A sender with exactly one stop bit is therefore tolerated with ±half-bit margin.
- **Acceptance.** A byte is accepted in the cycle where `rx_valid && rx_ready`. There is no combinational path from `rx_ready` to any output.
- **Pulse width.** `frame_err` and `overrun` are exactly one cycle wide and never assert in the same cycle.

## Structure
- **Shared package `uart_pkg`:**
  - state enum `uart_state_t` (IDLE, START, DATA, STOP, WAIT_HIGH), shared with the transmitter's first four states;
  - function `clks_per_bit(freq, baud)`.
- **Sub-module `sync_2ff`:** generic two-flop synchroniser, parameterised width and reset value, reusable for other asynchronous inputs.

## Test plan
All scenarios use `CLOCK_FREQ`=16, `BAUD_RATE`=1, giving `CLKS_PER_BIT`=16 and `HALF_BIT`=8.

- **Reset:** assert `rst` 3 cycles with `rx`=0 → `rx_data`=0x00, `rx_valid`=`frame_err`=`overrun`=0. After release with `rx`=1, no output.
- **Single byte:** `rx_ready`=1, send frame 0xA5 → `rx_valid` high for exactly 1 cycle, `rx_data`=0xA5, asserted 154 cycles after the falling edge.
- **Glitch:** `rx` low for 4 cycles then high → no `rx_valid`, no `frame_err`. A following 0x3C frame is received correctly.
- **Framing error:** send 0x3C with stop bit 0, then hold `rx` low 40 cycles → one `frame_err` pulse, no `rx_valid`. Then raise `rx` and send 0x7E → 0x7E delivered.
- **Backpressure and overrun:** `rx_ready`=0, send 0x11 then 0x22 back-to-back → `rx_valid`=1 holding 0x11, one `overrun` pulse at 0x22's stop sample. Raise `rx_ready` → 0x11 accepted and `rx_valid` falls.
- **Simultaneous accept, and reset mid-frame:**
  - Assert `rx_ready` exactly on 0x22's stop-sample cycle → no `overrun`; `rx_data`=0x22 and `rx_valid` stays 1.
  - Separately, pulse `rst` during bit 4 of a frame → no output for that frame; the next frame decodes correctly.
